// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry, decision encoding, r0 index.
// No logic; no latency; no backpressure.
// Entry rd is stored at SB_RD_W bits so any REG_IDX_W up to 8 fits without changing the struct.
package hazard_pkg;

    localparam int SB_RD_W = 8;
    localparam logic [SB_RD_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               isLoad;
    } sb_entry_t;

    typedef enum logic [1:0] {
        DEC_RUN,
        DEC_STALL,
        DEC_FLUSH,
        DEC_FREEZE
    } decision_t;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: REG_ZERO, isLoad: 1'b0};

endpackage

// File: rtl/hazard_sb_entry_cmp.sv
// RAW match of one in-flight destination against the sources of the instruction in ID.
// Purely combinational, zero latency; no backpressure.
// Writes to r0 never create a dependency.
module hazard_sb_entry_cmp
    import hazard_pkg::*;
#(
    parameter int REG_IDX_W = 4
) (
    input  sb_entry_t            entry,
    input  logic                 idValid,
    input  logic [REG_IDX_W-1:0] idRs1,
    input  logic [REG_IDX_W-1:0] idRs2,
    input  logic                 idUseRs1,
    input  logic                 idUseRs2,
    output logic                 hit
);

    logic [SB_RD_W-1:0] rs1_w;
    logic [SB_RD_W-1:0] rs2_w;
    logic               src_hit;

    assign rs1_w   = SB_RD_W'(idRs1);
    assign rs2_w   = SB_RD_W'(idRs2);
    assign src_hit = (idUseRs1 && (rs1_w == entry.rd)) || (idUseRs2 && (rs2_w == entry.rd));
    assign hit     = idValid && entry.valid && (entry.rd != REG_ZERO) && src_hit;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline-register enables/bubbles from freeze > mispredict flush > RAW stall; optional perf counters (HAZARD_PERF_EN).
// Decision is combinational (zero latency); the destination scoreboard updates on each non-frozen edge.
// memBusy freezes everything; stalls hold PC and IF/ID while a bubble enters ID/EX.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_IDX_W = 4,
    parameter int FWD_EN    = 1,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 idValid,
    input  logic [REG_IDX_W-1:0] idRs1,
    input  logic [REG_IDX_W-1:0] idRs2,
    input  logic                 idUseRs1,
    input  logic                 idUseRs2,
    input  logic [REG_IDX_W-1:0] idRd,
    input  logic                 idRegWrt,
    input  logic                 idIsLoad,
    input  logic                 exBrMispred,
    input  logic                 memBusy,
    output logic                 pcWrtEn,
    output logic                 ifIdWrtEn,
    output logic                 idExWrtEn,
    output logic                 exMemWrtEn,
    output logic                 memWbWrtEn,
    output logic                 ifIdFlush,
    output logic                 idExFlush,
    output logic                 stallData,
    output logic                 flushBr,
    output logic                 freeze
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]     perfStall,
    output logic [CNT_W-1:0]     perfFlush,
    output logic [CNT_W-1:0]     perfFreeze
`endif
);

    sb_entry_t exE, memE, wbE;
    logic      hit_ex, hit_mem, hit_wb;
    logic      data_hazard;
    logic      bubble_ex;
    decision_t dec;

    hazard_sb_entry_cmp #(.REG_IDX_W(REG_IDX_W)) u_cmp_ex (
        .entry(exE), .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2),
        .idUseRs1(idUseRs1), .idUseRs2(idUseRs2), .hit(hit_ex)
    );

    hazard_sb_entry_cmp #(.REG_IDX_W(REG_IDX_W)) u_cmp_mem (
        .entry(memE), .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2),
        .idUseRs1(idUseRs1), .idUseRs2(idUseRs2), .hit(hit_mem)
    );

    hazard_sb_entry_cmp #(.REG_IDX_W(REG_IDX_W)) u_cmp_wb (
        .entry(wbE), .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2),
        .idUseRs1(idUseRs1), .idUseRs2(idUseRs2), .hit(hit_wb)
    );

    // With forwarding only a load still in EX is too late; without it, every
    // older writer counts because the register file does not write through.
    assign data_hazard = (FWD_EN != 0) ? (hit_ex && exE.isLoad)
                                       : (hit_ex || hit_mem || hit_wb);

    always_comb begin
        dec = DEC_RUN;
        if (memBusy)
            dec = DEC_FREEZE;
        else if (exBrMispred)
            dec = DEC_FLUSH;
        else if (data_hazard)
            dec = DEC_STALL;
    end

    assign bubble_ex = (dec == DEC_FLUSH) || (dec == DEC_STALL);

    always_comb begin
        pcWrtEn    = 1'b0;
        ifIdWrtEn  = 1'b0;
        idExWrtEn  = 1'b0;
        exMemWrtEn = 1'b0;
        memWbWrtEn = 1'b0;
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;
        stallData  = 1'b0;
        flushBr    = 1'b0;
        freeze     = 1'b0;
        if (reset) begin
            unique case (dec)
                DEC_FREEZE: begin
                    freeze = 1'b1;
                end
                DEC_FLUSH: begin
                    flushBr    = 1'b1;
                    pcWrtEn    = 1'b1;
                    ifIdWrtEn  = 1'b1;
                    idExWrtEn  = 1'b1;
                    exMemWrtEn = 1'b1;
                    memWbWrtEn = 1'b1;
                    ifIdFlush  = 1'b1;
                    idExFlush  = 1'b1;
                end
                DEC_STALL: begin
                    stallData  = 1'b1;
                    idExWrtEn  = 1'b1;
                    exMemWrtEn = 1'b1;
                    memWbWrtEn = 1'b1;
                    idExFlush  = 1'b1;
                end
                default: begin
                    pcWrtEn    = 1'b1;
                    ifIdWrtEn  = 1'b1;
                    idExWrtEn  = 1'b1;
                    exMemWrtEn = 1'b1;
                    memWbWrtEn = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exE  <= SB_EMPTY;
            memE <= SB_EMPTY;
            wbE  <= SB_EMPTY;
        end else if (dec != DEC_FREEZE) begin
            wbE  <= memE;
            memE <= exE;
            exE  <= '{valid:  idValid && idRegWrt && !bubble_ex,
                      rd:     SB_RD_W'(idRd),
                      isLoad: idIsLoad};
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perfStall  <= '0;
            perfFlush  <= '0;
            perfFreeze <= '0;
        end else begin
            if (stallData)
                perfStall <= perfStall + CNT_W'(1);
            if (flushBr)
                perfFlush <= perfFlush + CNT_W'(1);
            if (freeze)
                perfFreeze <= perfFreeze + CNT_W'(1);
        end
    end
`endif

endmodule
